// File: rtl/pc_pkg.sv
// Shared definitions for the IF-stage next-PC generator.
//   PC_INC_C / PC_INC_N : sequential increments for 16-bit / 32-bit instructions
//   pc_src_e            : next-PC source, listed highest priority first
package pc_pkg;

  localparam int PC_INC_C = 2;
  localparam int PC_INC_N = 4;

  typedef enum logic [1:0] {
    SRC_TRAP  = 2'd0,
    SRC_REDIR = 2'd1,
    SRC_RAS   = 2'd2,
    SRC_SEQ   = 2'd3
  } pc_src_e;

  // Jump targets must be halfword aligned; bit 0 is simply discarded.
  function automatic logic [31:0] align_hw32(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_gen_ras_if.sv
// Control/status bundle between the fetch control logic and pc_gen_ras.
//   master : hazard unit / EX / trap logic side (drives control, reads PC + RAS status)
//   slave  : pc_gen_ras side
interface pc_gen_ras_if #(
  parameter int WIDTH = 32
);

  logic             stall;
  logic             compressed;
  logic             trap_valid;
  logic [WIDTH-1:0] trap_vec;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_miss;

  modport master (
    output stall, compressed, trap_valid, trap_vec,
           redirect_valid, redirect_pc, call, ret,
    input  pc, ras_empty, ras_full, ras_miss
  );

  modport slave (
    input  stall, compressed, trap_valid, trap_vec,
           redirect_valid, redirect_pc, call, ret,
    output pc, ras_empty, ras_full, ras_miss
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data as the new top entry
//   pop        : discard the top entry (ignored when empty)
//   push+pop   : replace the top entry in place, count/pointer unchanged
//   push_data  : address to push
//   top        : current top entry (valid when !empty)
//   empty/full : decoded from the registered entry count
// A push while full overwrites the oldest entry; the count saturates.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  // ptr_q is the next free slot; the top entry lives just below it.
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    wr_idx;
  logic             wr_en;
  logic             do_pop;

  assign top_idx = ptr_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign do_pop  = pop && !empty;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push && do_pop) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      // Power-of-two depth: pointer wrap overwrites the oldest slot.
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Next-PC generator for the IF stage with return-address prediction.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of pc_gen_ras_if
//     in : stall, compressed, trap_valid/trap_vec, redirect_valid/redirect_pc, call, ret
//     out: pc (registered fetch PC), ras_empty, ras_full, ras_miss (registered pulse)
// Priority: trap > redirect > stall (hold) > RAS prediction > sequential.
module pc_gen_ras
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst,
  pc_gen_ras_if.slave   bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty, ras_full;
  logic             ras_miss_q, ras_miss_d;
  logic             fetch_ok;
  logic             hold;
  logic             push, pop;
  pc_src_e          src;

  // Wraps modulo 2^WIDTH by construction.
  assign seq = pc_q + (bus.compressed ? WIDTH'(PC_INC_C) : WIDTH'(PC_INC_N));

  // Trap and redirect win over stall; call/ret only act on an undisturbed fetch.
  assign fetch_ok = !bus.trap_valid && !bus.redirect_valid && !bus.stall;
  assign hold     = bus.stall && !bus.trap_valid && !bus.redirect_valid;

  always_comb begin
    src = SRC_SEQ;
    if (bus.trap_valid)                src = SRC_TRAP;
    else if (bus.redirect_valid)       src = SRC_REDIR;
    else if (bus.ret && !ras_empty)    src = SRC_RAS;
  end

  always_comb begin
    pc_d = seq;
    unique case (src)
      SRC_TRAP:  pc_d = {bus.trap_vec[WIDTH-1:1], 1'b0};
      SRC_REDIR: pc_d = {bus.redirect_pc[WIDTH-1:1], 1'b0};
      SRC_RAS:   pc_d = ras_top;
      SRC_SEQ:   pc_d = seq;
      default:   pc_d = seq;
    endcase
    if (hold) pc_d = pc_q;
  end

  assign push       = fetch_ok && bus.call;
  assign pop        = fetch_ok && bus.ret && !ras_empty;
  assign ras_miss_d = fetch_ok && bus.ret && ras_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ras_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ras_miss_q <= ras_miss_d;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.pc        = pc_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_miss  = ras_miss_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Self-checking bench for pc_gen_ras: directed vector table, async reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_pc_gen_ras;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_gen_ras_if #(.WIDTH(32)) bus ();

  pc_gen_ras #(
    .WIDTH     (32),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        st, cp, tv;
    logic [31:0] tvec;
    logic        rv;
    logic [31:0] rpc;
    logic        ca, re;
    logic [31:0] e_pc;
    logic        e_empty, e_full, e_miss;
  } vec_t;

  vec_t tbl [34];

  function automatic vec_t mk(logic st, logic cp, logic tv, logic [31:0] tvec,
                              logic rv, logic [31:0] rpc, logic ca, logic re,
                              logic [31:0] epc, logic ee, logic ef, logic em);
    vec_t v;
    v.st = st; v.cp = cp; v.tv = tv; v.tvec = tvec; v.rv = rv; v.rpc = rpc;
    v.ca = ca; v.re = re; v.e_pc = epc; v.e_empty = ee; v.e_full = ef; v.e_miss = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic st, input logic cp, input logic tv, input logic [31:0] tvec,
                       input logic rv, input logic [31:0] rpc, input logic ca, input logic re);
    bus.stall = st; bus.compressed = cp; bus.trap_valid = tv; bus.trap_vec = tvec;
    bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.call = ca; bus.ret = re;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_empty", 32'(bus.ras_empty), 32'd1);
    chk("rst_full", 32'(bus.ras_full), 32'd0);
    chk("rst_miss", 32'(bus.ras_miss), 32'd0);
    rst = 1'b1;
  endtask

  // Reference model state: plain PC value plus a bounded queue of return addresses.
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_miss;

  task automatic model_step(input logic st, input logic cp, input logic tv, input logic [31:0] tvec,
                            input logic rv, input logic [31:0] rpc, input logic ca, input logic re);
    logic [31:0] seq;
    seq    = m_pc + (cp ? 32'd2 : 32'd4);
    m_miss = 1'b0;
    if (tv) m_pc = tvec & ~32'd1;
    else if (rv) m_pc = rpc & ~32'd1;
    else if (st) begin
    end else if (re && m_ras.size() > 0) begin
      m_pc = m_ras.pop_back();
      if (ca) m_ras.push_back(seq);
    end else begin
      m_pc   = seq;
      m_miss = re;
      if (ca) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
  endtask

  initial begin
    //             st cp tv tvec        rv rpc           ca re  pc            emp full miss
    tbl[0]  = mk(0, 0, 0, 0,          0, 0,            0, 0, 32'h4,        1, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0,          0, 0,            0, 0, 32'h6,        1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,          0, 0,            0, 0, 32'hA,        1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,          1, 32'h100,      0, 0, 32'h100,      1, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0,          0, 0,            0, 0, 32'h100,      1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0,          0, 0,            0, 0, 32'h100,      1, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0,          1, 32'h201,      0, 0, 32'h200,      1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,          1, 32'h40,       0, 0, 32'h40,       1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,          0, 0,            1, 0, 32'h44,       0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,          1, 32'h80,       0, 0, 32'h80,       0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h44,       1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h48,       1, 0, 1);
    tbl[12] = mk(0, 1, 0, 0,          0, 0,            0, 0, 32'h4A,       1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,          0, 0,            1, 0, 32'h4E,       0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,          0, 0,            1, 0, 32'h52,       0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0,          0, 0,            1, 0, 32'h54,       0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0,          0, 0,            1, 0, 32'h58,       0, 1, 0);
    tbl[17] = mk(0, 0, 0, 0,          0, 0,            1, 0, 32'h5C,       0, 1, 0);
    tbl[18] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h5C,       0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h58,       0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h54,       0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h52,       1, 0, 0);
    tbl[22] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h56,       1, 0, 1);
    tbl[23] = mk(0, 0, 0, 0,          0, 0,            0, 0, 32'h5A,       1, 0, 0);
    tbl[24] = mk(0, 0, 0, 0,          0, 0,            1, 0, 32'h5E,       0, 0, 0);
    tbl[25] = mk(1, 0, 1, 32'h1C0,    1, 32'h300,      1, 1, 32'h1C0,      0, 0, 0);
    tbl[26] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h5E,       1, 0, 0);
    tbl[27] = mk(0, 0, 0, 0,          0, 0,            1, 1, 32'h62,       0, 0, 1);
    tbl[28] = mk(0, 1, 0, 0,          0, 0,            1, 1, 32'h62,       0, 0, 0);
    tbl[29] = mk(0, 0, 0, 0,          0, 0,            0, 1, 32'h64,       1, 0, 0);
    tbl[30] = mk(1, 0, 0, 0,          0, 0,            1, 1, 32'h64,       1, 0, 0);
    tbl[31] = mk(0, 0, 1, 32'h301,    0, 0,            0, 0, 32'h300,      1, 0, 0);
    tbl[32] = mk(0, 0, 0, 0,          1, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFC, 1, 0, 0);
    tbl[33] = mk(0, 0, 0, 0,          0, 0,            0, 0, 32'h0,        1, 0, 0);

    do_reset();

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].st, tbl[i].cp, tbl[i].tv, tbl[i].tvec,
            tbl[i].rv, tbl[i].rpc, tbl[i].ca, tbl[i].re);
      step();
      chk($sformatf("vec%0d_pc", i), bus.pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_empty", i), 32'(bus.ras_empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d_full", i), 32'(bus.ras_full), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d_miss", i), 32'(bus.ras_miss), 32'(tbl[i].e_miss));
    end

    // Asynchronous reset in the middle of a push cycle.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    chk("pre_arst_pc", bus.pc, 32'h8);
    chk("pre_arst_empty", 32'(bus.ras_empty), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_empty", 32'(bus.ras_empty), 32'd1);
    chk("arst_full", 32'(bus.ras_full), 32'd0);
    #2 rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("post_arst_pc", bus.pc, 32'h4);
    chk("post_arst_miss", 32'(bus.ras_miss), 32'd1);
    chk("post_arst_empty", 32'(bus.ras_empty), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("post_arst_miss_drop", 32'(bus.ras_miss), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_miss = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic st, cp, tv, rv, ca, re;
      logic [31:0] tvec, rpc;
      st   = ($urandom_range(0, 5) == 0);
      cp   = $urandom_range(0, 1) == 1;
      tv   = ($urandom_range(0, 15) == 0);
      rv   = ($urandom_range(0, 9) == 0);
      ca   = ($urandom_range(0, 3) == 0);
      re   = ($urandom_range(0, 3) == 0);
      tvec = $urandom;
      rpc  = (n % 97 == 0) ? 32'hFFFFFFFD : $urandom;
      drive(st, cp, tv, tvec, rv, rpc, ca, re);
      model_step(st, cp, tv, tvec, rv, rpc, ca, re);
      step();
      chk("rnd_pc", bus.pc, m_pc);
      chk("rnd_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
      chk("rnd_full", 32'(bus.ras_full), 32'(m_ras.size() == DEPTH));
      chk("rnd_miss", 32'(bus.ras_miss), 32'(m_miss));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
